// File: rtl/jtframe_debug_sel.sv
// rtl/jtframe_debug_sel.sv - debug key driven 8-bit selector with auto-repeat and OSD show window
//
// Purpose: turns the debug keys into an 8-bit debug_bus value. up/down step by
// 1 (or 16 with key_shift), clr returns to zero, and a held key auto-repeats.
// Build option: define JTFRAME_DEBUG_REPEAT_EN to enable auto-repeat; without
// it every press gives exactly one step and HOLD_DLY/REP_PER are unused.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   key_up     increment key (level, synchronised)
//   key_down   decrement key (level, synchronised)
//   key_shift  step of 16 instead of 1
//   key_clr    clear key (level, synchronised)
//   lock       ignore all keys while high
//   debug_bus  selector value
//   bus_upd    one-cycle pulse when debug_bus changes
//   show       high while the OSD should display debug_bus

module jtframe_debug_sel #(
  parameter logic [23:0] HOLD_DLY = 24'd6_000_000,
  parameter logic [23:0] REP_PER  = 24'd1_200_000,
  parameter logic [23:0] SHOW_DLY = 24'd12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_shift,
  input  logic       key_clr,
  input  logic       lock,
  output logic [7:0] debug_bus,
  output logic       bus_upd,
  output logic       show
);

  localparam int SW = $clog2(SHOW_DLY) + 1;
  localparam logic [SW-1:0] SHOW_LOAD = SW'(SHOW_DLY - 24'd1);

  // key history: {clr, down, up}
  logic [2:0]    hist;
  logic          up_press, down_press, clr_press;
  logic [7:0]    step_amt;
  logic          step_en, step_up, clr_bus;
  logic [7:0]    bus_nx;
  logic [SW-1:0] show_cnt;

  assign up_press   = key_up   & ~hist[0];
  assign down_press = key_down & ~hist[1];
  assign clr_press  = key_clr  & ~hist[2];
  assign step_amt   = key_shift ? 8'd16 : 8'd1;

`ifdef JTFRAME_DEBUG_REPEAT_EN
  localparam logic [23:0] CMAX = (HOLD_DLY > REP_PER) ? HOLD_DLY : REP_PER;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DLY - 24'd1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_PER - 24'd1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t        state, state_nx;
  logic          dir, dir_nx;     // 1 = up
  logic [CW-1:0] cnt, cnt_nx;
  logic          held;

  assign held = dir ? key_up : key_down;

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    cnt_nx   = cnt;
    step_en  = 1'b0;
    step_up  = dir;
    clr_bus  = 1'b0;
    if (lock) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (clr_press) begin
      clr_bus  = 1'b1;
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (key_up && key_down) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (state != IDLE && held) begin
      if (state == HOLD && cnt == HOLD_LAST) begin
        state_nx = REPEAT;
        step_en  = 1'b1;
        cnt_nx   = '0;
      end else if (state == REPEAT && cnt == REP_LAST) begin
        step_en  = 1'b1;
        cnt_nx   = '0;
      end else begin
        cnt_nx   = cnt + CW'(1);
      end
    end else begin
      // Idle, or the active key was just released: a press of either key
      // in this same cycle still starts a new step.
      state_nx = IDLE;
      cnt_nx   = '0;
      if (up_press || down_press) begin
        step_en  = 1'b1;
        step_up  = up_press;
        dir_nx   = up_press;
        state_nx = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
      cnt   <= cnt_nx;
    end
  end
`else
  logic [47:0] unused_cfg;
  assign unused_cfg = {HOLD_DLY, REP_PER};

  always_comb begin
    step_en = 1'b0;
    step_up = up_press;
    clr_bus = 1'b0;
    if (!lock) begin
      if (clr_press)
        clr_bus = 1'b1;
      else if (!(key_up && key_down) && (up_press || down_press))
        step_en = 1'b1;
    end
  end
`endif

  always_comb begin
    bus_nx = debug_bus;
    if (clr_bus)
      bus_nx = 8'd0;
    else if (step_en)
      bus_nx = step_up ? debug_bus + step_amt : debug_bus - step_amt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= 3'd0;
      debug_bus <= 8'd0;
      bus_upd   <= 1'b0;
      show_cnt  <= '0;
    end else begin
      hist      <= {key_clr, key_down, key_up};
      debug_bus <= bus_nx;
      bus_upd   <= (bus_nx != debug_bus);
      // bus_upd itself covers the first show cycle, the counter the rest
      if (bus_upd)
        show_cnt <= SHOW_LOAD;
      else if (show_cnt != '0)
        show_cnt <= show_cnt - SW'(1);
    end
  end

  assign show = bus_upd | (show_cnt != '0);

endmodule
